dwt_frame_sequencer: RTL and testbench
======================================

# dwt_frame_sequencer

Frame-level controller for the Daubechies-3 analysis datapath (`dwt4db`). It walks the sample ROM through one frame, drives `dwt4db` with registered samples and a decimation phase, zero-pads the filter tail, and tags the decimated `a1`/`d1` outputs with a valid strobe and coefficient index. It replaces the free-running 0–999 counter so that frames start on command, end cleanly with a done pulse, and can run back-to-back.

## Interface
- `FRAME_LEN`, 1000: real samples per frame (even, ≥ 2).
- `ADDR_W`, 10: ROM address width; 2**ADDR_W ≥ FRAME_LEN.
- `DATA_W`, 16: signed sample width.
- `FLUSH_LEN`, 6: zero samples appended per frame (even; equals db3 tap count).
- `LAT`, 2: cycles from a sample on `x` to the corresponding `dwt4db` output (≥ 1).
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; sampled only in IDLE.
- `loop` in 1: sampled in DONE; 1 restarts a frame immediately.
- `abort` in 1: synchronous abort; takes effect in any state.
- `rom_addr` out ADDR_W: ROM address (ROM read is combinational).
- `rom_data` in DATA_W: ROM word at `rom_addr`.
- `x` out DATA_W signed: registered sample to `dwt4db`.
- `x_valid` out 1: `x` carries a frame sample (real or pad).
- `phase` out 1: parity of the sample index on `x` (0 even, 1 odd); the half-rate `clk2` equivalent.
- `coef_valid` out 1: `a1`/`d1` at the `dwt4db` outputs form a valid decimated pair this cycle.
- `coef_idx` out 16: index of that pair, 0 … (FRAME_LEN+FLUSH_LEN)/2−1.
- `busy` out 1: high in RUN, FLUSH, DRAIN, and DONE.
- `done` out 1: one-cycle pulse at the end of each frame.
- `frame_cnt` out 16: number of completed frames; wraps at 2**16.

## Operation
- States: IDLE, RUN, FLUSH, DRAIN, DONE.
- IDLE:
  - `rom_addr`=0, `x`=0, `x_valid`=0, `phase`=0.
  - `start`=1 → RUN.
- RUN:
  - `rom_addr` steps 0 … FRAME_LEN−1, one address per cycle.
  - Each cycle, `x`←`rom_data` and `x_valid`←1.
  - After `rom_addr`=FRAME_LEN−1 → FLUSH, with `rom_addr`←0.
- FLUSH:
  - FLUSH_LEN cycles with `x`←0 and `x_valid`←1.
  - Then → DRAIN.
- DRAIN:
  - `x_valid`←0 and `x`←0.
  - Stay LAT cycles while the pipeline empties, then → DONE.
- DONE:
  - Lasts one cycle; `done`=1; `frame_cnt`+1.
  - `loop`=1 → RUN with `rom_addr`=0; otherwise → IDLE.
- Sample index and `phase`:
  - The index k counts the samples presented on `x` in the frame, pad included: 0 … FRAME_LEN+FLUSH_LEN−1.
  - `phase` = k[0] while `x_valid`=1; otherwise 0.
- Coefficient tagging:
  - `coef_valid` = (`x_valid` & `phase`) delayed by LAT cycles.
  - This is a shift register that reset and abort clear.
  - `coef_idx` increments after each `coef_valid` and clears at frame start.
- `start` outside IDLE is ignored. `loop` outside DONE is ignored.
- `abort`: next cycle is IDLE with all outputs at IDLE values. `coef_valid` pipeline and `coef_idx` are cleared. No `done`. `frame_cnt` is unchanged.
- `rst` has the same effect as `abort`, and also clears `frame_cnt`.
- `rst` takes priority over `abort`; `abort` takes priority over `start` and `loop`.

## Timing
- Reset values: every output is 0.
- For `start` sampled at cycle 0 with the defaults:
  - Cycle 1: RUN, `rom_addr`=0.
  - Sample k appears on `x` at cycle k+2.
  - Cycles 1–1000: `rom_addr` = cycle−1.
  - Cycles 2–1001: real samples on `x`.
  - Cycles 1002–1007: padded zeros on `x`.
  - Cycles 1008–1009: DRAIN, `x_valid`=0.
  - `coef_valid` is high at cycles 5, 7, …, 1009, for 503 pairs with `coef_idx` 0…502.
  - Cycle 1010: `done`=1.
  - Cycle 1011: IDLE, or RUN with `rom_addr`=0 if `loop`=1.
- `busy` is high in cycles 1–1010.
- With `loop`, frames run back-to-back with a 1-cycle DONE gap, so the period is 1010 cycles.
- Frame latency in general:
  - First `x_valid` is 2 cycles after `start`.
  - `done` is FRAME_LEN+FLUSH_LEN+LAT+2 cycles after `start`.

## Structure
- Shared package `dwt_pkg` holds:
  - the state enum;
  - defaults for DATA_W, FRAME_LEN, FLUSH_LEN, and LAT;
  - the sample type.
- Sub-module `delay_line` (parameter DEPTH=LAT, 1-bit, synchronous clear) for the `coef_valid` pipeline.
- The FSM, address counter, flush/drain counter, and index counters stay in the top module.

## Test plan
- Reset, then idle for 20 cycles → all outputs 0, `rom_addr`=0.
- `start` pulse with ROM[k]=k → `x`=k at cycle k+2; `phase` alternates 0,1; six zeros after `x`=999; `done` at cycle 1010; `frame_cnt`=1; 503 `coef_valid` pulses, last with `coef_idx`=502.
- `loop` held at 1 for 3 frames → `done` at 1010, 2020, 3030; `frame_cnt`=3; `coef_idx` restarts at 0 each frame.
- `abort` at cycle 500 → IDLE at 501; no `done`; `frame_cnt` unchanged; a new `start` gives the first `x` exactly 2 cycles later with `phase`=0.
- `rst` asserted during FLUSH → every output 0 next cycle, including `frame_cnt`; `coef_valid` stays 0 afterwards with no stale pulse.
- `start` held high during RUN and `loop`=0 → no restart; exactly one frame runs per IDLE visit, and back-to-back only if `start` is still high in IDLE.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared types and default parameters for the dwt frame sequencer.
package dwt_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int FRAME_LEN_DEF = 1000;
    localparam int FLUSH_LEN_DEF = 6;
    localparam int LAT_DEF       = 2;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/delay_line.sv
// Single-bit shift register with synchronous reset and clear.
module delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_r;

    // Shift din through DEPTH stages; reset and clear flush every stage.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr_r <= '0;
        end else begin
            sr_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_r[i] <= sr_r[i-1];
            end
        end
    end

    assign dout = sr_r[DEPTH-1];

endmodule

// File: rtl/dwt_frame_sequencer.sv
// Frame controller feeding dwt4db: ROM walk, zero pad, drain, coefficient tags.
module dwt_frame_sequencer
    import dwt_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FLUSH_LEN = FLUSH_LEN_DEF,
    parameter int LAT       = LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     loop,
    input  logic                     abort,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic signed [DATA_W-1:0] rom_data,
    output logic signed [DATA_W-1:0] x,
    output logic                     x_valid,
    output logic                     phase,
    output logic                     coef_valid,
    output logic [15:0]              coef_idx,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              frame_cnt
);

    localparam int CNT_W = 8;

    state_t                    state_r,   state_s;
    logic [ADDR_W-1:0]         addr_r,    addr_s;
    logic [CNT_W-1:0]          cnt_r,     cnt_s;
    logic signed [DATA_W-1:0]  x_r,       x_s;
    logic                      xv_r,      xv_s;
    logic                      ph_r,      ph_s;
    logic                      busy_r,    busy_s;
    logic                      done_r,    done_s;
    logic [15:0]               fc_r,      fc_s;
    logic [15:0]               idx_r,     idx_s;
    logic                      coef_valid_s;

    // Next-state and next-output logic; abort forces the idle values last.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        cnt_s   = cnt_r;
        x_s     = '0;
        xv_s    = 1'b0;
        ph_s    = 1'b0;
        fc_s    = fc_r;
        idx_s   = coef_valid_s ? idx_r + 16'd1 : idx_r;

        case (state_r)
            ST_IDLE: begin
                addr_s = '0;
                if (start) begin
                    state_s = ST_RUN;
                    idx_s   = 16'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                x_s  = rom_data;
                xv_s = 1'b1;
                // Sample index equals the address during the real samples.
                ph_s = addr_r[0];
                if (addr_r == ADDR_W'(FRAME_LEN - 1)) begin
                    state_s = ST_FLUSH;
                    addr_s  = '0;
                    cnt_s   = '0;
                end else begin
                    addr_s = addr_r + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                xv_s = 1'b1;
                // FRAME_LEN is even, so pad parity follows the pad counter.
                ph_s = cnt_r[0];
                if (cnt_r == CNT_W'(FLUSH_LEN - 1)) begin
                    state_s = ST_DRAIN;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // LAT+1 cycles: the x register adds one stage ahead of dwt4db.
                if (cnt_r == CNT_W'(LAT)) begin
                    state_s = ST_DONE;
                    cnt_s   = '0;
                    fc_s    = fc_r + 16'd1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                addr_s = '0;
                if (loop) begin
                    state_s = ST_RUN;
                    idx_s   = 16'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                addr_s  = '0;
                cnt_s   = '0;
            end
        endcase

        if (abort) begin
            state_s = ST_IDLE;
            addr_s  = '0;
            cnt_s   = '0;
            x_s     = '0;
            xv_s    = 1'b0;
            ph_s    = 1'b0;
            fc_s    = fc_r;
            idx_s   = 16'd0;
        end else begin
            idx_s = idx_s;
        end

        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State and output registers; reset returns everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            cnt_r   <= '0;
            x_r     <= '0;
            xv_r    <= 1'b0;
            ph_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fc_r    <= 16'd0;
            idx_r   <= 16'd0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            cnt_r   <= cnt_s;
            x_r     <= x_s;
            xv_r    <= xv_s;
            ph_r    <= ph_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            fc_r    <= fc_s;
            idx_r   <= idx_s;
        end
    end

    // Odd samples complete a decimated pair LAT cycles after leaving x.
    delay_line #(
        .DEPTH(LAT)
    ) u_coef_dly (
        .clk (clk),
        .rst (rst),
        .clr (abort),
        .din (xv_r & ph_r),
        .dout(coef_valid_s)
    );

    assign rom_addr   = addr_r;
    assign x          = x_r;
    assign x_valid    = xv_r;
    assign phase      = ph_r;
    assign coef_valid = coef_valid_s;
    assign coef_idx   = idx_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign frame_cnt  = fc_r;

endmodule

// File: tb/tb_dwt_frame_sequencer.sv
// Randomized bench for dwt_frame_sequencer against a frame-timeline model.
module tb_dwt_frame_sequencer;
    import dwt_pkg::*;

    localparam int F  = 1000;
    localparam int FL = 6;
    localparam int L  = 2;
    localparam int P  = F + FL + L + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, loop, abort;
    logic [9:0]         rom_addr;
    logic signed [15:0] rom_data, x;
    logic               x_valid, phase, coef_valid, busy, done;
    logic [15:0]        coef_idx, frame_cnt;

    sample_t rom [0:1023];
    assign rom_data = rom[rom_addr];

    dwt_frame_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .loop(loop), .abort(abort),
        .rom_addr(rom_addr), .rom_data(rom_data), .x(x), .x_valid(x_valid),
        .phase(phase), .coef_valid(coef_valid), .coef_idx(coef_idx),
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    int total = 0;
    int bad   = 0;
    // Model: t = cycles since the frame's start command (0 = idle).
    int t     = 0;
    int m_fc  = 0;
    int m_idx = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    function automatic bit m_xv(input int tt);
        int k = tt - 2;
        return (k >= 0) && (k < F + FL);
    endfunction

    function automatic logic [31:0] m_x(input int tt);
        int k = tt - 2;
        logic [15:0] v;
        v = 16'd0;
        if (k >= 0 && k < F) v = rom[k];
        return {16'd0, v};
    endfunction

    function automatic bit m_cv(input int tt);
        int j = tt - 2 - L;
        return (j >= 0) && (j < F + FL) && (j % 2 == 1);
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            t = 0; m_fc = 0; m_idx = 0;
        end else if (abort) begin
            t = 0; m_idx = 0;
        end else begin
            if (m_cv(t)) m_idx = (m_idx + 1) % 65536;
            if (t == 0) begin
                if (start) begin t = 1; m_idx = 0; end
            end else if (t == P) begin
                if (loop) begin t = 1; m_idx = 0; end
                else t = 0;
            end else begin
                t++;
            end
            if (t == P) m_fc = (m_fc + 1) % 65536;
        end
        #1;
        check("rom_addr",   {22'd0, rom_addr}, (t >= 1 && t <= F) ? t - 1 : 0);
        check("x",          {16'd0, x}, m_x(t));
        check("x_valid",    {31'd0, x_valid}, {31'd0, m_xv(t)});
        check("phase",      {31'd0, phase}, m_xv(t) ? (t - 2) % 2 : 0);
        check("coef_valid", {31'd0, coef_valid}, {31'd0, m_cv(t)});
        check("coef_idx",   {16'd0, coef_idx}, m_idx);
        check("busy",       {31'd0, busy}, (t >= 1 && t <= P) ? 1 : 0);
        check("done",       {31'd0, done}, (t == P) ? 1 : 0);
        check("frame_cnt",  {16'd0, frame_cnt}, m_fc);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic rand_rom();
        for (int k = 0; k < 1024; k++) rom[k] = sample_t'($urandom_range(0, 65535));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; loop = 1'b0; abort = 1'b0;
        for (int k = 0; k < 1024; k++) rom[k] = sample_t'(k);
        run(3);
        rst = 1'b0;
        run(20);

        // Single frame with ROM[k]=k.
        start = 1'b1; run(1); start = 1'b0;
        run(P + 5);

        // Three looped frames.
        rand_rom();
        loop = 1'b1; start = 1'b1; run(1); start = 1'b0;
        run(3 * P - 3);
        loop = 1'b0;
        run(10);

        // Abort at cycle 500, then restart.
        rand_rom();
        start = 1'b1; run(1); start = 1'b0;
        run(499);
        abort = 1'b1; run(1); abort = 1'b0;
        run(5);
        start = 1'b1; run(1); start = 1'b0;
        run(P + 3);

        // Reset while padding zeros.
        start = 1'b1; run(1); start = 1'b0;
        run(1002);
        rst = 1'b1; run(1); rst = 1'b0;
        run(20);

        // Start held high with loop low.
        start = 1'b1;
        run(2 * P + 5);
        start = 1'b0;
        run(10);

        // Random control traffic.
        rand_rom();
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 19) == 0);
            loop  = ($urandom_range(0, 1) == 1);
            abort = ($urandom_range(0, 599) == 0);
            rst   = ($urandom_range(0, 1999) == 0);
            step();
        end
        start = 1'b0; loop = 1'b0; abort = 1'b0; rst = 1'b0;
        run(P + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
